// File: rtl/multicycle_adder_pkg.sv
// Shared definitions for the multicycle adder: FSM state encoding and chunk-count helper.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package multicycle_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of RUN cycles for one operation; width must be a whole number of chunks.
  function automatic int num_chunks(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/multicycle_adder_if.sv
// Request/result bundle between a requester (master) and the multicycle adder (slave).
// Latency: n/a (wiring only).
// Backpressure: none; master watches busy/done, start is ignored while busy.
// Signals: start/sub/cin/a/b from master; sum/cout/ovf/busy/done from slave.
interface multicycle_adder_if #(
  parameter int WIDTH = 5
);

  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (
    output start, sub, cin, a, b,
    input  sum, cout, ovf, busy, done
  );

  modport slave (
    input  start, sub, cin, a, b,
    output sum, cout, ovf, busy, done
  );

endinterface

// File: rtl/chunk_adder.sv
// One CHUNK-bit slice of the serial adder: a + b + cin, purely combinational.
// Latency: 0 cycles.
// Backpressure: none.
// Ports: a, b (CHUNK), cin -> sum (CHUNK), cout, msb_cin (carry into the slice MSB).
module chunk_adder #(
  parameter int CHUNK = 1
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             msb_cin
);

  logic [CHUNK:0] w_total;

  assign w_total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign sum     = w_total[CHUNK-1:0];
  assign cout    = w_total[CHUNK];
  // The sum bit is a ^ b ^ carry-in, so the carry into the MSB can be recovered from it.
  assign msb_cin = a[CHUNK-1] ^ b[CHUNK-1] ^ sum[CHUNK-1];

endmodule

// File: rtl/multicycle_adder.sv
// Serial adder/subtractor processing CHUNK bits per cycle, LSB chunk first.
// Latency: done pulses WIDTH/CHUNK cycles after the edge that samples start.
// Backpressure: start ignored while busy; accepted in IDLE or in the DONE cycle.
// Ports: clk, rst_n (async active-low), bus (slave side of multicycle_adder_if).
module multicycle_adder
  import multicycle_adder_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int CHUNK = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multicycle_adder_if.slave     bus
);

  localparam int NCH   = num_chunks(WIDTH, CHUNK);
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_load;
  logic             w_step;
  logic             w_last;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] w_acc_next;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;

  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK-1:0] w_chunk_sum;
  logic             w_chunk_cout;
  logic             w_msb_cin;

  assign w_last = (r_idx == IDX_W'(NCH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_load       = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        bus.busy = 1'b1;
        w_step   = 1'b1;
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        bus.done = 1'b1;
        // Re-arming straight from DONE gives back-to-back operations.
        if (bus.start) begin
          w_load       = 1'b1;
          w_state_next = RUN;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_a_chunk = r_a[r_idx*CHUNK +: CHUNK];
  assign w_b_chunk = r_b[r_idx*CHUNK +: CHUNK];

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_adder (
    .a       (w_a_chunk),
    .b       (w_b_chunk),
    .cin     (r_carry),
    .sum     (w_chunk_sum),
    .cout    (w_chunk_cout),
    .msb_cin (w_msb_cin)
  );

  always_comb begin
    w_acc_next = r_acc;
    w_acc_next[r_idx*CHUNK +: CHUNK] = w_chunk_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_load) begin
      // Subtraction is a + ~b + 1, so the operand is inverted and the carry seeded with 1.
      r_a     <= bus.a;
      r_b     <= bus.sub ? ~bus.b : bus.b;
      r_acc   <= '0;
      r_idx   <= '0;
      r_carry <= bus.sub | bus.cin;
    end else if (w_step) begin
      r_acc   <= w_acc_next;
      r_carry <= w_chunk_cout;
      r_idx   <= r_idx + 1'b1;
      // Visible results change only as the FSM enters DONE.
      if (w_last) begin
        r_sum  <= w_acc_next;
        r_cout <= w_chunk_cout;
        r_ovf  <= w_chunk_cout ^ w_msb_cin;
      end
    end
  end

  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_multicycle_adder.sv
// Bench for multicycle_adder: three instances (5b/1-bit chunks, 8b/4-bit chunks, 8b/8-bit chunks).
// Expected results come from signed/unsigned integer arithmetic; a scoreboard ring per instance
// is filled when an accepted start is seen and drained by a negedge monitor.
module tb_multicycle_adder;

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         due;
  } exp_t;

  logic clk;
  logic rst_n;

  multicycle_adder_if #(.WIDTH(5)) bus0 ();
  multicycle_adder_if #(.WIDTH(8)) bus1 ();
  multicycle_adder_if #(.WIDTH(8)) bus2 ();

  multicycle_adder #(.WIDTH(5), .CHUNK(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  multicycle_adder #(.WIDTH(8), .CHUNK(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  multicycle_adder #(.WIDTH(8), .CHUNK(8)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  int   cyc;
  int   total;
  int   bad;
  int   head    [3];
  int   tail    [3];
  int   next_ok [3];
  exp_t ring    [3][4];
  exp_t last    [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input int w, input int a, input int b, input bit ci, input bit sb);
    exp_t e;
    int m, half, sa, sbv, sr, raw;
    m    = 1 << w;
    half = m / 2;
    sa   = (a >= half) ? a - m : a;
    sbv  = (b >= half) ? b - m : b;
    if (sb) begin
      raw    = a - b;
      sr     = sa - sbv;
      e.cout = (a >= b);
    end else begin
      raw    = a + b + int'(ci);
      sr     = sa + sbv + int'(ci);
      e.cout = (raw >= m);
    end
    e.sum = 8'(((raw % m) + m) % m);
    e.ovf = (sr < -half) || (sr >= half);
    e.due = 0;
    return e;
  endfunction

  task automatic chk(input string nm, input int id, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", nm, id, cyc, got, want);
    end
  endtask

  task automatic accept(input int id, input int w, input int nch, input bit st,
                        input bit sb, input bit ci, input int a, input int b);
    exp_t e;
    if (st && cyc >= next_ok[id]) begin
      e            = model(w, a, b, ci, sb);
      e.due        = cyc + nch;
      ring[id][tail[id]] = e;
      tail[id]     = (tail[id] + 1) % 4;
      next_ok[id]  = cyc + nch + 1;
    end
  endtask

  // Reference side: decide which starts are accepted and what they must produce.
  always @(posedge clk) begin
    cyc++;
    if (rst_n) begin
      accept(0, 5, 5, bus0.start, bus0.sub, bus0.cin, int'(bus0.a), int'(bus0.b));
      accept(1, 8, 2, bus1.start, bus1.sub, bus1.cin, int'(bus1.a), int'(bus1.b));
      accept(2, 8, 1, bus2.start, bus2.sub, bus2.cin, int'(bus2.a), int'(bus2.b));
    end
  end

  task automatic mon(input int id, input logic [7:0] s, input logic co, input logic ov,
                     input logic bz, input logic dn);
    bit   have, exp_dn, exp_bz;
    exp_t f;
    have   = (head[id] != tail[id]);
    f      = ring[id][head[id]];
    exp_dn = have && (cyc == f.due);
    exp_bz = have && (cyc < f.due);
    chk("done", id, int'(dn), int'(exp_dn));
    chk("busy", id, int'(bz), int'(exp_bz));
    if (exp_dn) begin
      last[id] = f;
      head[id] = (head[id] + 1) % 4;
    end
    chk("sum", id, int'(s), int'(last[id].sum));
    chk("cout", id, int'(co), int'(last[id].cout));
    chk("ovf", id, int'(ov), int'(last[id].ovf));
  endtask

  always @(negedge clk) begin
    mon(0, {3'b000, bus0.sum}, bus0.cout, bus0.ovf, bus0.busy, bus0.done);
    mon(1, bus1.sum, bus1.cout, bus1.ovf, bus1.busy, bus1.done);
    mon(2, bus2.sum, bus2.cout, bus2.ovf, bus2.busy, bus2.done);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive0(input bit st, input bit sb, input bit ci, input logic [4:0] a, input logic [4:0] b);
    bus0.start = st; bus0.sub = sb; bus0.cin = ci; bus0.a = a; bus0.b = b;
  endtask

  task automatic drive8(input bit st1, input bit st2, input bit sb, input bit ci,
                        input logic [7:0] a, input logic [7:0] b);
    bus1.start = st1; bus1.sub = sb; bus1.cin = ci; bus1.a = a; bus1.b = b;
    bus2.start = st2; bus2.sub = sb; bus2.cin = ci; bus2.a = a; bus2.b = b;
  endtask

  task automatic rand_drive(input int pct);
    bus0.start = ($urandom_range(0, 99) < pct);
    bus0.sub   = 1'($urandom_range(0, 1));
    bus0.cin   = 1'($urandom_range(0, 1));
    bus0.a     = 5'($urandom);
    bus0.b     = 5'($urandom);
    bus1.start = ($urandom_range(0, 99) < pct);
    bus1.sub   = 1'($urandom_range(0, 1));
    bus1.cin   = 1'($urandom_range(0, 1));
    bus1.a     = 8'($urandom);
    bus1.b     = 8'($urandom);
    bus2.start = ($urandom_range(0, 99) < pct);
    bus2.sub   = 1'($urandom_range(0, 1));
    bus2.cin   = 1'($urandom_range(0, 1));
    bus2.a     = 8'($urandom);
    bus2.b     = 8'($urandom);
  endtask

  function automatic logic done_of(input int id);
    case (id)
      0:       return bus0.done;
      1:       return bus1.done;
      default: return bus2.done;
    endcase
  endfunction

  task automatic wait_done(input int id, input int budget, output int lat);
    lat = 0;
    while (lat < budget) begin
      tick();
      lat++;
      if (done_of(id)) return;
    end
    total++;
    bad++;
    $display("FAIL done_timeout dut%0d cyc=%0d got=no_done want=done_within_%0d", id, cyc, budget);
  endtask

  // Assert reset, expect every output to drop at once, and forget all pending work.
  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      head[i]    = 0;
      tail[i]    = 0;
      next_ok[i] = 0;
      last[i]    = '0;
    end
    #1;
    chk("rst_out", 0, int'({bus0.sum, bus0.cout, bus0.ovf, bus0.busy, bus0.done}), 0);
    chk("rst_out", 1, int'({bus1.sum, bus1.cout, bus1.ovf, bus1.busy, bus1.done}), 0);
    chk("rst_out", 2, int'({bus2.sum, bus2.cout, bus2.ovf, bus2.busy, bus2.done}), 0);
    tick();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    rst_n = 1'b0;
    drive0(1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    drive8(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    repeat (3) tick();
    chk("init_out", 0, int'({bus0.sum, bus0.cout, bus0.ovf, bus0.busy, bus0.done}), 0);
    chk("init_out", 1, int'({bus1.sum, bus1.cout, bus1.ovf, bus1.busy, bus1.done}), 0);
    chk("init_out", 2, int'({bus2.sum, bus2.cout, bus2.ovf, bus2.busy, bus2.done}), 0);
    rst_n = 1'b1;
    tick();

    // 21 + 18: operands scrambled right after acceptance must not matter.
    drive0(1'b1, 1'b0, 1'b0, 5'b10101, 5'b10010);
    tick();
    drive0(1'b0, 1'b1, 1'b1, 5'b11111, 5'b11111);
    wait_done(0, 20, lat);
    chk("add_lat", 0, lat, 5);
    chk("add_sum", 0, int'(bus0.sum), 5'b00111);
    chk("add_cout", 0, int'(bus0.cout), 1);
    chk("add_ovf", 0, int'(bus0.ovf), 1);
    tick();

    // 3 - 5 with cin set, which subtraction must ignore.
    drive0(1'b1, 1'b1, 1'b1, 5'b00011, 5'b00101);
    tick();
    drive0(1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    wait_done(0, 20, lat);
    chk("sub_lat", 0, lat, 5);
    chk("sub_sum", 0, int'(bus0.sum), 5'b11110);
    chk("sub_cout", 0, int'(bus0.cout), 0);
    chk("sub_ovf", 0, int'(bus0.ovf), 0);
    tick();

    // 0x7F + 0x01 on the 4-bit-chunk and the single-chunk instances.
    drive8(1'b1, 1'b0, 1'b0, 1'b0, 8'h7F, 8'h01);
    tick();
    drive8(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    wait_done(1, 20, lat);
    chk("c4_lat", 1, lat, 2);
    chk("c4_sum", 1, int'(bus1.sum), 8'h80);
    chk("c4_cout", 1, int'(bus1.cout), 0);
    chk("c4_ovf", 1, int'(bus1.ovf), 1);
    tick();
    drive8(1'b0, 1'b1, 1'b0, 1'b0, 8'h7F, 8'h01);
    tick();
    drive8(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    wait_done(2, 20, lat);
    chk("c8_lat", 2, lat, 1);
    chk("c8_sum", 2, int'(bus2.sum), 8'h80);
    chk("c8_cout", 2, int'(bus2.cout), 0);
    chk("c8_ovf", 2, int'(bus2.ovf), 1);
    tick();

    // start held high with operands changing every cycle: back-to-back operations.
    repeat (24) begin
      rand_drive(100);
      tick();
    end
    drive0(1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    drive8(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    repeat (8) tick();

    // Second start during RUN with new operands must be ignored: result is 9 + 13.
    drive0(1'b1, 1'b0, 1'b0, 5'd9, 5'd13);
    tick();
    drive0(1'b0, 1'b0, 1'b0, 5'd9, 5'd13);
    tick();
    drive0(1'b1, 1'b1, 1'b1, 5'd31, 5'd4);
    tick();
    drive0(1'b0, 1'b0, 1'b0, 5'd1, 5'd2);
    wait_done(0, 20, lat);
    chk("ign_sum", 0, int'(bus0.sum), 5'b10110);
    chk("ign_cout", 0, int'(bus0.cout), 0);
    chk("ign_ovf", 0, int'(bus0.ovf), 1);
    tick();

    // Reset while chunk 3 is being processed, then restart on the first edge after release.
    drive0(1'b1, 1'b0, 1'b0, 5'd7, 5'd7);
    tick();
    drive0(1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    repeat (3) tick();
    do_reset();
    drive0(1'b1, 1'b0, 1'b1, 5'd4, 5'd2);
    rst_n = 1'b1;
    tick();
    drive0(1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    wait_done(0, 20, lat);
    chk("rst_restart_lat", 0, lat, 5);
    chk("rst_restart_sum", 0, int'(bus0.sum), 5'd7);
    tick();

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
        rst_n = 1'b1;
      end else begin
        rand_drive(40);
        tick();
      end
    end

    drive0(1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    drive8(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    repeat (15) tick();
    for (int i = 0; i < 3; i++) begin
      chk("drain", i, (tail[i] - head[i] + 4) % 4, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
